// File: rtl/btn_debounce_multi_pkg.sv
// Shared types and defaults for the multi-channel button debouncer.
// Imported by the channel, the interface users and the top level.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW_STABLE,
      RISE_PEND,
      HIGH_STABLE,
      FALL_PEND
   } db_state_t;

   localparam int unsigned DB_DEFAULT_WAIT = 2_500_000;
   localparam int unsigned DB_DEFAULT_LONG = 100_000_000;

   // Counter width able to hold 0..n, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n == 0) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button bundle between the board pins and the control FSMs.
// The master drives raw buttons; the slave returns debounced events.
interface btn_debounce_multi_if #(
   parameter int unsigned N_CH = 4
);

   logic [N_CH-1:0] btn;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] press_pls;
   logic [N_CH-1:0] release_pls;
   logic [N_CH-1:0] long_pls;

   modport master (
      output btn,
      input  btn_level,
      input  press_pls,
      input  release_pls,
      input  long_pls
   );

   modport slave (
      input  btn,
      output btn_level,
      output press_pls,
      output release_pls,
      output long_pls
   );

endinterface

// File: rtl/btn_debounce_multi_ch.sv
// One debounce channel: synchroniser, stability counter, pulses
// and the long-press hold timer.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_WAIT = DB_DEFAULT_WAIT,
   parameter int unsigned LONG_WAIT     = DB_DEFAULT_LONG,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int unsigned DW = cnt_width(DEBOUNCE_WAIT);
   localparam int unsigned HW = cnt_width(LONG_WAIT);
   localparam bit LONG_EN = (LONG_WAIT > 0);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_WAIT - 1);
   localparam logic [HW-1:0] H_LAST =
      HW'(LONG_EN ? LONG_WAIT - 1 : 0);

   db_state_t     state_q;
   logic          s1_q;
   logic          s2_q;
   logic          level_q;
   logic          press_q;
   logic          release_q;
   logic          long_q;
   logic          done_q;
   logic [DW-1:0] dcnt_q;
   logic [DW-1:0] dcnt_d;
   logic [HW-1:0] hcnt_q;
   logic [HW-1:0] hcnt_d;
   logic          fall_d;

   assign dcnt_d = dcnt_q + DW'(1);
   assign hcnt_d = hcnt_q + HW'(1);
   // A fall accepted this edge beats a long press landing on it.
   assign fall_d = level_q && !s2_q && (dcnt_q == D_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= LOW_STABLE;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         done_q    <= 1'b0;
         dcnt_q    <= '0;
         hcnt_q    <= '0;
      end else begin
         s1_q      <= btn_i ^ ACTIVE_LOW;
         s2_q      <= s1_q;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         unique case (state_q)
            LOW_STABLE, RISE_PEND: begin
               if (!s2_q) begin
                  state_q <= LOW_STABLE;
                  dcnt_q  <= '0;
               end else if (dcnt_q == D_LAST) begin
                  state_q <= HIGH_STABLE;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
                  dcnt_q  <= '0;
               end else begin
                  state_q <= RISE_PEND;
                  dcnt_q  <= dcnt_d;
               end
            end
            HIGH_STABLE, FALL_PEND: begin
               if (s2_q) begin
                  state_q <= HIGH_STABLE;
                  dcnt_q  <= '0;
               end else if (dcnt_q == D_LAST) begin
                  state_q   <= LOW_STABLE;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
                  dcnt_q    <= '0;
               end else begin
                  state_q <= FALL_PEND;
                  dcnt_q  <= dcnt_d;
               end
            end
            default: begin
               state_q <= LOW_STABLE;
               level_q <= 1'b0;
               dcnt_q  <= '0;
            end
         endcase
         if (!LONG_EN || !level_q || fall_d) begin
            hcnt_q <= '0;
            done_q <= 1'b0;
         end else if (!done_q) begin
            hcnt_q <= hcnt_d;
            if (hcnt_q == H_LAST) begin
               long_q <= 1'b1;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N independent debounce channels behind the board's button pins.
// Outputs of each channel are gathered into the shared bundle.
module btn_debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned DEBOUNCE_WAIT = DB_DEFAULT_WAIT,
   parameter int unsigned LONG_WAIT     = DB_DEFAULT_LONG,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input logic             clk,
   input logic             rst_n,
   btn_debounce_multi_if.slave bus
);

   logic [N_CH-1:0] level_w;
   logic [N_CH-1:0] press_w;
   logic [N_CH-1:0] release_w;
   logic [N_CH-1:0] long_w;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_WAIT (DEBOUNCE_WAIT),
         .LONG_WAIT     (LONG_WAIT),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_i     (bus.btn[i]),
         .level_o   (level_w[i]),
         .press_o   (press_w[i]),
         .release_o (release_w[i]),
         .long_o    (long_w[i])
      );
   end

   assign bus.btn_level   = level_w;
   assign bus.press_pls   = press_w;
   assign bus.release_pls = release_w;
   assign bus.long_pls    = long_w;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench: two debouncers (active-high x2, active-low x1) against
// a timestamp-based model, plus directed timing pins.
module tb_btn_debounce_multi;

   localparam int W = 4;
   localparam int L = 10;

   logic clk;
   logic rst_n;

   btn_debounce_multi_if #(.N_CH(2)) a_if ();
   btn_debounce_multi_if #(.N_CH(1)) b_if ();

   btn_debounce_multi #(
      .N_CH(2), .DEBOUNCE_WAIT(W), .LONG_WAIT(L), .ACTIVE_LOW(1'b0)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if)
   );

   btn_debounce_multi #(
      .N_CH(1), .DEBOUNCE_WAIT(W), .LONG_WAIT(0), .ACTIVE_LOW(1'b1)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Model state: synchronised value pipeline, accepted level,
   // length of the current mismatch run, and when the level rose.
   bit m_s1[3], m_s2[3], m_lvl[3];
   bit m_pr[3], m_rl[3], m_lg[3];
   int m_run[3], m_rise[3];

   int press_cnt[3], press_cyc[3];
   int rel_cnt[3], rel_cyc[3];
   int long_cnt[3], long_cyc[3];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic bit raw_of(input int c);
      if (c < 2) return a_if.btn[c[0]];
      return b_if.btn[0];
   endfunction

   function automatic logic [3:0] act_of(input int c);
      if (c < 2)
         return {a_if.btn_level[c[0]], a_if.press_pls[c[0]],
                 a_if.release_pls[c[0]], a_if.long_pls[c[0]]};
      return {b_if.btn_level[0], b_if.press_pls[0],
              b_if.release_pls[0], b_if.long_pls[0]};
   endfunction

   task automatic model_step(input int c, input bit rs, input bit raw);
      bit old;
      bit fell;
      bit al;
      int lw;
      al = (c == 2);
      lw = (c < 2) ? L : 0;
      m_pr[c] = 0;
      m_rl[c] = 0;
      m_lg[c] = 0;
      if (!rs) begin
         m_s1[c] = 0;
         m_s2[c] = 0;
         m_lvl[c] = 0;
         m_run[c] = 0;
         return;
      end
      old = m_lvl[c];
      fell = 0;
      if (m_s2[c] != m_lvl[c]) begin
         m_run[c]++;
         if (m_run[c] == W) begin
            m_lvl[c] = m_s2[c];
            m_run[c] = 0;
            if (m_lvl[c]) begin
               m_pr[c] = 1;
               m_rise[c] = cyc;
            end else begin
               m_rl[c] = 1;
               fell = 1;
            end
         end
      end else begin
         m_run[c] = 0;
      end
      if (lw > 0 && old && !fell && (cyc - m_rise[c] == lw))
         m_lg[c] = 1;
      m_s2[c] = m_s1[c];
      m_s1[c] = raw ^ al;
   endtask

   initial begin
      bit rs;
      bit raws[3];
      logic [3:0] act, exp;
      forever begin
         @(posedge clk);
         rs = rst_n;
         for (int c = 0; c < 3; c++) raws[c] = raw_of(c);
         cyc++;
         for (int c = 0; c < 3; c++) model_step(c, rs, raws[c]);
         #1;
         for (int c = 0; c < 3; c++) begin
            act = act_of(c);
            exp = {m_lvl[c], m_pr[c], m_rl[c], m_lg[c]};
            n_chk++;
            if (act !== exp) begin
               n_fail++;
               $display("FAIL model ch%0d cycle %0d: lvl/pr/rl/lg got %b required %b",
                        c, cyc, act, exp);
            end
            if (act[2] === 1'b1) begin press_cnt[c]++; press_cyc[c] = cyc; end
            if (act[1] === 1'b1) begin rel_cnt[c]++;   rel_cyc[c] = cyc;   end
            if (act[0] === 1'b1) begin long_cnt[c]++;  long_cyc[c] = cyc;  end
         end
      end
   end

   initial begin
      int k, rise, pc, rc, lc, t;
      bit cur[3];
      int hold[3];

      rst_n = 1'b0;
      a_if.btn = '0;
      b_if.btn = '1;
      repeat (3) @(negedge clk);
      chk("reset_a", int'({a_if.btn_level, a_if.press_pls,
                           a_if.release_pls, a_if.long_pls}), 0);
      chk("reset_b", int'({b_if.btn_level, b_if.press_pls,
                           b_if.release_pls, b_if.long_pls}), 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("al_no_pulse_at_reset", press_cnt[2] + rel_cnt[2], 0);

      // Clean press on channel 0
      a_if.btn[0] = 1'b1;
      k = cyc + 1;
      repeat (8) @(negedge clk);
      chk("clean_press_edge", press_cyc[0], k + 5);
      chk("clean_press_count", press_cnt[0], 1);
      chk("clean_level0", int'(a_if.btn_level[0]), 1);
      chk("clean_level1", int'(a_if.btn_level[1]), 0);
      a_if.btn[0] = 1'b0;
      repeat (12) @(negedge clk);

      // Bounce then hold
      pc = press_cnt[0];
      a_if.btn[0] = 1'b1; @(negedge clk);
      a_if.btn[0] = 1'b0; @(negedge clk);
      a_if.btn[0] = 1'b1; @(negedge clk);
      a_if.btn[0] = 1'b0; @(negedge clk);
      a_if.btn[0] = 1'b1;
      k = cyc + 1;
      repeat (10) @(negedge clk);
      chk("bounce_press_count", press_cnt[0], pc + 1);
      chk("bounce_press_edge", press_cyc[0], k + 5);
      a_if.btn[0] = 1'b0;
      repeat (12) @(negedge clk);

      // Long press and release on channel 1
      a_if.btn[1] = 1'b1;
      rise = cyc + 6;
      repeat (26) @(negedge clk);
      a_if.btn[1] = 1'b0;
      k = cyc + 1;
      repeat (8) @(negedge clk);
      chk("long_count", long_cnt[1], 1);
      chk("long_edge", long_cyc[1], rise + 10);
      chk("long_release_edge", rel_cyc[1], k + 5);
      chk("long_release_count", rel_cnt[1], 1);

      // Short press: level high for 6 cycles
      pc = press_cnt[0]; rc = rel_cnt[0]; lc = long_cnt[0];
      a_if.btn[0] = 1'b1;
      rise = cyc + 6;
      repeat (6) @(negedge clk);
      a_if.btn[0] = 1'b0;
      repeat (12) @(negedge clk);
      chk("short_press_count", press_cnt[0], pc + 1);
      chk("short_release_count", rel_cnt[0], rc + 1);
      chk("short_release_edge", rel_cyc[0], rise + 6);
      chk("short_no_long", long_cnt[0], lc);

      // Release accepted on the very edge the hold timer expires
      lc = long_cnt[0];
      a_if.btn[0] = 1'b1;
      rise = cyc + 6;
      repeat (10) @(negedge clk);
      a_if.btn[0] = 1'b0;
      repeat (12) @(negedge clk);
      chk("tie_release_edge", rel_cyc[0], rise + 10);
      chk("tie_no_long", long_cnt[0], lc);

      // Reset while the rise count sits at 2
      pc = press_cnt[0]; rc = rel_cnt[0];
      a_if.btn[0] = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_outputs", int'({a_if.btn_level, a_if.press_pls,
                                    a_if.release_pls, a_if.long_pls}), 0);
      rst_n = 1'b1;
      t = cyc;
      repeat (8) @(negedge clk);
      chk("midreset_press_edge", press_cyc[0], t + 6);
      chk("midreset_press_count", press_cnt[0], pc + 1);
      chk("midreset_no_release", rel_cnt[0], rc);
      a_if.btn[0] = 1'b0;
      repeat (12) @(negedge clk);

      // Active-low channel press
      b_if.btn[0] = 1'b0;
      k = cyc + 1;
      repeat (8) @(negedge clk);
      chk("al_press_edge", press_cyc[2], k + 5);
      chk("al_level", int'(b_if.btn_level[0]), 1);
      b_if.btn[0] = 1'b1;
      repeat (12) @(negedge clk);

      // Random bounce/hold mix with occasional resets
      cur[0] = a_if.btn[0];
      cur[1] = a_if.btn[1];
      cur[2] = b_if.btn[0];
      for (int c = 0; c < 3; c++) hold[c] = 0;
      for (int n = 0; n < 4000; n++) begin
         for (int c = 0; c < 3; c++) begin
            if (hold[c] == 0) begin
               cur[c] = ~cur[c];
               hold[c] = ($urandom_range(0, 1) == 1) ?
                         int'($urandom_range(1, 3)) :
                         int'($urandom_range(4, 30));
            end else begin
               hold[c]--;
            end
         end
         a_if.btn[0] = cur[0];
         a_if.btn[1] = cur[1];
         b_if.btn[0] = cur[2];
         rst_n = ($urandom_range(0, 499) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
